// File: rtl/commu_bert.sv
// Byte-stream BERT: emits a fixed/incrementing/PRBS7 word stream on a valid/ready
// link and checks the looped-back stream against an identical local generator.
module commu_bert #(
  parameter int          DW        = 8,
  parameter int          CW        = 32,
  parameter int unsigned FIXED_PAT = 8'h55,
  parameter int          GAP_CYC   = 16,
  parameter int          DRAIN_CYC = 1000000
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] tx_total,
  input  logic [1:0]    tx_mode,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic [CW-1:0] rx_total,
  output logic [CW-1:0] err_total,
  output logic          now_send,
  output logic          done,
  output logic          pass
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] FIX_W      = DW'(FIXED_PAT);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [TW-1:0] DRAIN_LAST = TW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_DRAIN, S_DONE} state_t;

  // Mode 3 falls through to the fixed pattern.
  function automatic logic [DW-1:0] pat_seed(input logic [1:0] m);
    case (m)
      2'd1:    return '0;
      2'd2:    return DW'(7'h7F);
      default: return FIX_W;
    endcase
  endfunction

  function automatic logic [DW-1:0] pat_next(input logic [1:0] m, input logic [DW-1:0] w);
    case (m)
      2'd1:    return w + DW'(1);
      2'd2:    return DW'({w[5:0], w[6] ^ w[5]});
      default: return FIX_W;
    endcase
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] total_q, total_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] sent_q, sent_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] gen_q, gen_d;
  logic [DW-1:0] chk_q, chk_d;
  logic [CW-1:0] rx_total_q, rx_total_d;
  logic [CW-1:0] err_q, err_d;
  logic          chk_act;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      total_q    <= '0;
      mode_q     <= '0;
      sent_q     <= '0;
      gap_q      <= '0;
      timer_q    <= '0;
      gen_q      <= FIX_W;
      chk_q      <= FIX_W;
      rx_total_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      mode_q     <= mode_d;
      sent_q     <= sent_d;
      gap_q      <= gap_d;
      timer_q    <= timer_d;
      gen_q      <= gen_d;
      chk_q      <= chk_d;
      rx_total_q <= rx_total_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    mode_d     = mode_q;
    sent_d     = sent_q;
    gap_d      = gap_q;
    timer_d    = timer_q;
    gen_d      = gen_q;
    chk_d      = chk_q;
    rx_total_d = rx_total_q;
    err_d      = err_q;
    chk_act    = (state_q == S_SEND) || (state_q == S_GAP) || (state_q == S_DRAIN);

    // The checker word advances on every received word so one bad word is one error.
    if (chk_act && rx_valid) begin
      rx_total_d = sat_inc(rx_total_q);
      if (rx_data != chk_q) err_d = sat_inc(err_q);
      chk_d = pat_next(mode_q, chk_q);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          total_d    = tx_total;
          mode_d     = tx_mode;
          sent_d     = '0;
          gap_d      = '0;
          timer_d    = '0;
          rx_total_d = '0;
          err_d      = '0;
          gen_d      = pat_seed(tx_mode);
          chk_d      = pat_seed(tx_mode);
          state_d    = (tx_total == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          gen_d  = pat_next(mode_q, gen_q);
          sent_d = sent_q + CW'(1);
          gap_d  = '0;
          if (sent_q + CW'(1) == total_q) state_d = S_DRAIN;
          else if (GAP_CYC != 0)          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_SEND;
        else                   gap_d   = gap_q + GW'(1);
      end
      S_DRAIN: begin
        if ((rx_total_q == total_q) || (timer_q == DRAIN_LAST)) state_d = S_DONE;
        else                                                    timer_d = timer_q + TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Data is gated so nothing stale shows on the link outside SEND.
  assign tx_valid  = (state_q == S_SEND);
  assign tx_data   = tx_valid ? gen_q : '0;
  assign now_send  = (state_q == S_SEND) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0) && (rx_total_q == total_q);
  assign rx_total  = rx_total_q;
  assign err_total = err_q;

endmodule

// File: tb/tb_commu_bert.sv
// Directed bench for commu_bert: 2-cycle loopback with optional corrupt/drop,
// backpressure, zero-length run and mid-run reset.
module tb_commu_bert;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int GAP = 16;
  localparam int DRAIN = 100;

  logic          clk_sys = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] tx_total = '0;
  logic [1:0]    tx_mode = '0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [CW-1:0] rx_total;
  logic [CW-1:0] err_total;
  logic          now_send;
  logic          done;
  logic          pass;

  int n_tests = 0;
  int n_fail = 0;

  commu_bert #(.DW(DW), .CW(CW), .FIXED_PAT(8'h55), .GAP_CYC(GAP), .DRAIN_CYC(DRAIN)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .start(start), .tx_total(tx_total), .tx_mode(tx_mode),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_total(rx_total), .err_total(err_total), .now_send(now_send),
    .done(done), .pass(pass)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Loopback: handshakes are visible at the negedge before the accepting posedge.
  logic          v1 = 1'b0, v2 = 1'b0;
  logic [DW-1:0] d1 = '0, d2 = '0;
  int            lb_n = 0, hs_n = 0;
  int            corrupt_idx = -1, drop_idx = -1;
  logic [DW-1:0] hs_log [512];
  int            hs_cyc [512];

  always @(negedge clk_sys) begin
    if (!rst_n) begin
      v1 = 1'b0; v2 = 1'b0; rx_valid = 1'b0;
    end else begin
      rx_valid = v2; rx_data = d2;
      v2 = v1; d2 = d1; v1 = 1'b0;
      if (tx_valid && tx_ready) begin
        if (hs_n < 512) begin hs_log[hs_n] = tx_data; hs_cyc[hs_n] = cyc; end
        hs_n++;
        if (lb_n != drop_idx) begin
          v1 = 1'b1;
          d1 = (lb_n == corrupt_idx) ? (tx_data ^ 8'h01) : tx_data;
        end
        lb_n++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic start_run(input int total, input logic [1:0] mode);
    hs_n = 0; lb_n = 0;
    tx_total = total; tx_mode = mode; start = 1'b1;
    tick();
    start = 1'b0;
    if (total != 0) check("done_clr", done, 1'b0);
  endtask

  task automatic wait_done(input int budget, output int drain_k, output int done_k);
    int k = 0;
    drain_k = -1;
    while (!done && k < budget) begin
      if (drain_k < 0 && !now_send) drain_k = k;
      tick(); k++;
    end
    done_k = k;
    check("run_done", done, 1'b1);
  endtask

  logic [7:0] prbs_exp [8] = '{8'h7F, 8'h7E, 8'h7C, 8'h78, 8'h70, 8'h60, 8'h40, 8'h01};

  initial begin
    int e, d, bad;
    logic [DW-1:0] held;

    repeat (3) tick();
    check("rst_txv", tx_valid, 0);  check("rst_txd", tx_data, 0);
    check("rst_rx", rx_total, 0);   check("rst_err", err_total, 0);
    check("rst_ns", now_send, 0);   check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    rst_n = 1'b1; tick();

    // Fixed pattern with gaps
    start_run(8, 2'd0); wait_done(600, e, d);
    check("m0_rx", rx_total, 8); check("m0_err", err_total, 0); check("m0_pass", pass, 1);
    check("m0_hs", hs_n, 8);
    bad = 0;
    for (int i = 0; i < 8; i++) if (hs_log[i] != 8'h55) bad++;
    check("m0_words", bad, 0);
    bad = 0;
    for (int i = 1; i < 8; i++) if (hs_cyc[i] - hs_cyc[i-1] != GAP + 1) bad++;
    check("m0_gaps", bad, 0);

    // Incrementing with wrap
    start_run(300, 2'd1); wait_done(6000, e, d);
    check("m1_rx", rx_total, 300); check("m1_err", err_total, 0); check("m1_pass", pass, 1);
    check("m1_hs", hs_n, 300);
    bad = 0;
    for (int i = 0; i < 300; i++) if (hs_log[i] != 8'(i)) bad++;
    check("m1_seq", bad, 0);
    check("m1_w256", hs_log[256], 8'd0); check("m1_w299", hs_log[299], 8'd43);

    // PRBS7
    start_run(8, 2'd2); wait_done(600, e, d);
    for (int i = 0; i < 8; i++) check($sformatf("m2_w%0d", i), hs_log[i], prbs_exp[i]);
    check("m2_pass", pass, 1); check("m2_err", err_total, 0);

    // Single corrupted word
    corrupt_idx = 3;
    start_run(8, 2'd1); wait_done(600, e, d);
    corrupt_idx = -1;
    check("cor_err", err_total, 1); check("cor_rx", rx_total, 8); check("cor_pass", pass, 0);

    // Dropped word: drain timeout
    drop_idx = 5;
    start_run(8, 2'd0); wait_done(600, e, d);
    drop_idx = -1;
    check("drop_rx", rx_total, 7); check("drop_pass", pass, 0);
    check("drop_drain", d - e, DRAIN);

    // Backpressure on the first word
    tx_ready = 1'b0;
    start_run(4, 2'd1);
    held = tx_data;
    check("bp_valid0", tx_valid, 1); check("bp_data0", held, 8'h00);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!tx_valid || tx_data != held) bad++;
    end
    check("bp_stable", bad, 0);
    tx_ready = 1'b1;
    wait_done(600, e, d);
    check("bp_hs", hs_n, 4); check("bp_w1", hs_log[1], 8'h01);
    check("bp_rx", rx_total, 4); check("bp_err", err_total, 0); check("bp_pass", pass, 1);

    // Zero-length run
    start_run(0, 2'd1);
    check("z_done", done, 1); check("z_pass", pass, 1);
    check("z_rx", rx_total, 0); check("z_ns", now_send, 0);

    // Mode 3 behaves as fixed
    start_run(2, 2'd3); wait_done(600, e, d);
    check("m3_w0", hs_log[0], 8'h55); check("m3_w1", hs_log[1], 8'h55); check("m3_pass", pass, 1);

    // Reset mid-SEND, asynchronous
    start_run(8, 2'd1);
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_txv", tx_valid, 0);  check("ar_txd", tx_data, 0);
    check("ar_rx", rx_total, 0);   check("ar_err", err_total, 0);
    check("ar_ns", now_send, 0);   check("ar_done", done, 0);
    check("ar_pass", pass, 0);
    tick(); rst_n = 1'b1; tick();

    // Clean run after reset
    start_run(4, 2'd2); wait_done(600, e, d);
    check("post_rx", rx_total, 4); check("post_w3", hs_log[3], 8'h78); check("post_pass", pass, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/commu_bert.md
Name: commu_bert

Overview:
- Byte-stream pattern generator and checker for the serial link test designs.
- Sends a configurable number of words in one of three data patterns to the UART transmitter over a valid/ready stream.
- Independently regenerates the same sequence to check words returned by the UART receiver.
- Reports received count, error count, busy, done and pass. It is the parametrised successor to the fixed-pattern commu test path, intended to be driven by top-level configuration wires and LEDs.

Parameters:
- DW, 8, data word width in bits (≥7).
- CW, 32, width of the total/count/error counters.
- FIXED_PAT, 8'h55, word sent in fixed mode; zero-extended or truncated to DW.
- GAP_CYC, 16, idle clk_sys cycles inserted between accepted tx words (0 = back-to-back).
- DRAIN_CYC, 1000000, max clk_sys cycles to wait for outstanding rx words after last tx.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run.
- tx_total  in  CW  number of words to send; sampled on accepted start.
- tx_mode  in  2  0 fixed, 1 incrementing, 2 PRBS7, 3 treated as fixed; sampled on start.
- tx_data  out  DW  word to transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the word when tx_valid&tx_ready.
- rx_data  in  DW  word from receiver.
- rx_valid  in  1  one-cycle strobe per received word.
- rx_total  out  CW  words received this run.
- err_total  out  CW  mismatching words this run.
- now_send  out  1  high in SEND and GAP.
- done  out  1  high in DONE.
- pass  out  1  done & err_total==0 & rx_total==tx_total latched.

Behaviour:
- Single clock domain, clk_sys. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Generator and checker states at pattern seed.
- FSM states: IDLE, SEND, GAP, DRAIN, DONE.
- IDLE/DONE + start:
  - Latch tx_total and tx_mode.
  - Clear rx_total, err_total, sent count and drain timer.
  - Reseed tx and rx generators.
  - Go to SEND next cycle, or straight to DONE if tx_total==0 (pass=1).
- start in SEND/GAP/DRAIN: ignored.
- SEND:
  - tx_valid=1 with tx_data = current generator word, held stable until tx_ready.
  - On handshake, advance the generator and increment sent.
  - If sent+1==tx_total, go to DRAIN (tx_valid drops next cycle); otherwise go to GAP. If GAP_CYC==0, stay in SEND.
- GAP: tx_valid=0 for exactly GAP_CYC cycles, then SEND.
- DRAIN:
  - Timer counts from 0.
  - Go to DONE when rx_total==tx_total, or when the timer reaches DRAIN_CYC-1.
- DONE: hold counters and flags until the next start or reset.
- Patterns (tx and rx generators identical, both reseeded on start):
  - Fixed: every word is FIXED_PAT.
  - Incrementing: starts at 0, +1 per word, wraps at 2^DW.
  - PRBS7: lfsr seed 7'h7F; word = zero-extended lfsr; step lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}. Sequence: 7F,7E,7C,78,70,60,40,01,...
- Checker:
  - Active in SEND, GAP and DRAIN only; rx_valid in IDLE/DONE is ignored.
  - Each rx_valid increments rx_total (saturating at 2^CW-1) and compares rx_data to the checker word.
  - On mismatch, increment err_total (saturating).
  - The checker word always advances, so a single corrupted word counts as one error.
  - Extra words beyond tx_total are counted and checked; pass is then 0.
- rx_valid and a tx handshake in the same cycle are independent; both take effect.
- rx_valid on the cycle DRAIN exits to DONE: counted.
- Reset mid-run: immediate return to IDLE with all outputs 0; no partial word is held on tx_valid.
- pass and done update in the same cycle as DONE entry; both clear on the next accepted start.

Test Plan:
- Loopback (tx_data→rx_data, 2-cycle delay), mode 0, tx_total=8, GAP_CYC=16 -> eight 0x55 words, each separated by 16 idle cycles; done=1, rx_total=8, err_total=0, pass=1.
- Mode 1, tx_total=300, loopback -> words 0..255 then 0..43; pass=1, err_total=0.
- Mode 2, tx_total=8 -> tx_data sequence 7F,7E,7C,78,70,60,40,01; pass=1.
- Loopback with 4th word XOR 0x01 -> err_total=1, rx_total=8, pass=0.
- Loopback dropping one word, DRAIN_CYC=100 -> DONE exactly 100 cycles after DRAIN entry; rx_total=7, pass=0.
- Backpressure and corners:
  - tx_ready low for 5 cycles mid-word -> tx_data stable, no duplicate.
  - tx_total=0 -> DONE with pass=1 on the cycle after start.
  - rst_n low during SEND -> all outputs 0 asynchronously.
  - Subsequent start runs cleanly.
